// File: rtl/lut_sweep_delay.sv
// Programmable N-input truth-table evaluator with a LAT-deep registered result pipe.
// A sweep FSM walks every input vector in ascending order; IDLE also accepts external vectors.
module lut_sweep_delay #(
    parameter int N_IN = 3,
    parameter int LAT  = 2,
    parameter int HOLD = 1,
    localparam int TT_W = 1 << N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tt_load,
    input  logic [TT_W-1:0] tt_data,
    input  logic            start,
    input  logic            ext_en,
    input  logic [N_IN-1:0] ext_in,
    output logic [N_IN-1:0] vec_out,
    output logic            q,
    output logic            q_valid,
    output logic            busy,
    output logic            done
);

    localparam logic [7:0]      HOLD_LAST  = 8'(HOLD - 1);
    localparam logic [N_IN-1:0] VEC_LAST   = {N_IN{1'b1}};
    localparam logic [3:0]      DRAIN_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] vec_cnt, vec_nxt;
    logic [7:0]      hold_cnt, hold_nxt;
    logic [3:0]      drain_cnt, drain_nxt;
    logic [TT_W-1:0] tt;
    logic            tt_we;
    logic            issue;
    logic [N_IN-1:0] issue_vec;

    logic [LAT-1:0]  vld_p;
    logic [N_IN-1:0] vec_p [LAT];
    logic [LAT-1:0]  bit_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec_cnt   <= '0;
            hold_cnt  <= '0;
            drain_cnt <= '0;
            tt        <= '0;
        end else begin
            state     <= state_nxt;
            vec_cnt   <= vec_nxt;
            hold_cnt  <= hold_nxt;
            drain_cnt <= drain_nxt;
            if (tt_we) tt <= tt_data;
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec_cnt;
        hold_nxt  = hold_cnt;
        drain_nxt = drain_cnt;
        issue     = 1'b0;
        issue_vec = vec_cnt;
        tt_we     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                tt_we = tt_load;
                if (start) begin
                    state_nxt = SWEEP;
                    vec_nxt   = '0;
                    hold_nxt  = '0;
                end else if (ext_en) begin
                    issue     = 1'b1;
                    issue_vec = ext_in;
                end
            end
            SWEEP: begin
                busy  = 1'b1;
                issue = (hold_cnt == 8'd0);
                if (hold_cnt == HOLD_LAST) begin
                    hold_nxt = '0;
                    // Counter stops on all-ones rather than wrapping back to zero.
                    if (vec_cnt == VEC_LAST) begin
                        state_nxt = (LAT == 1) ? DONE : DRAIN;
                        drain_nxt = DRAIN_INIT;
                    end else begin
                        vec_nxt = vec_cnt + 1'b1;
                    end
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 4'd0) state_nxt = DONE;
                else                   drain_nxt = drain_cnt - 4'd1;
            end
            DONE: begin
                done      = 1'b1;
                tt_we     = tt_load;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Stage 0 samples the table at issue; later stages only advance on a valid
    // entry, so the last stage holds its value across bubbles.
    always_ff @(posedge clk) begin
        if (issue) begin
            vec_p[0] <= issue_vec;
            bit_p[0] <= tt[issue_vec];
        end
        // Stage i-1 -> stage i
        for (int i = 1; i < LAT; i++) begin
            if (vld_p[i-1]) begin
                vec_p[i] <= vec_p[i-1];
                bit_p[i] <= bit_p[i-1];
            end
        end
        if (rst) begin
            vec_p[LAT-1] <= '0;
            bit_p[LAT-1] <= 1'b0;
        end
    end

    assign vec_out = vec_p[LAT-1];
    assign q       = bit_p[LAT-1];
    assign q_valid = vld_p[LAT-1];

endmodule
